// File: rtl/cc_pkg.sv
// Shared types and widths for the CC operand bus and its frame driver.
package cc_pkg;

   localparam int CC_NUM_OPS = 6;
   localparam int CC_OP_W    = 4;
   localparam int CC_RES_W   = 10;
   localparam int CC_OPT_W   = 3;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT,
      OUT
   } cc_drv_state_t;

endpackage

// File: rtl/cc_frame_driver.sv
// Assembles a six-operand frame from nibble beats, holds it stable on the CC bus,
// captures CC's result after RESP_LAT cycles and hands it off over valid/ready.
module cc_frame_driver
   import cc_pkg::*;
#(
   parameter int unsigned RESP_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CC_OP_W-1:0]  in_data,
   input  logic [CC_OPT_W-1:0] in_opt,
   input  logic                in_equ,
   output logic [CC_OP_W-1:0]  cc_n0,
   output logic [CC_OP_W-1:0]  cc_n1,
   output logic [CC_OP_W-1:0]  cc_n2,
   output logic [CC_OP_W-1:0]  cc_n3,
   output logic [CC_OP_W-1:0]  cc_n4,
   output logic [CC_OP_W-1:0]  cc_n5,
   output logic [CC_OPT_W-1:0] cc_opt,
   output logic                cc_equ,
   input  logic [CC_RES_W-1:0] cc_out_n,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CC_RES_W-1:0] out_value
);

   cc_drv_state_t       state_q;
   logic [2:0]          beat_q;
   logic [2:0]          wait_q;
   logic                in_ready_q;
   logic                out_valid_q;
   logic [CC_RES_W-1:0] out_value_q;
   logic [CC_OPT_W-1:0] opt_q;
   logic                equ_q;
   logic [CC_OP_W-1:0]  ops_q [CC_NUM_OPS];
   logic                accept;

   // in_ready is a flop, so it stays low through reset and rises one edge later.
   assign accept = in_valid && in_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         wait_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         opt_q       <= '0;
         equ_q       <= 1'b0;
         // NOTE: the operand array is reset too, because an aborted frame must leave no residue on the CC bus.
         for (int k = 0; k < CC_NUM_OPS; k++) begin
            ops_q[k] <= '0;
         end
      end else begin
         // NOTE: every state register uses <= so all updates see pre-edge values.
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept) begin
                  ops_q[0] <= in_data;
                  opt_q    <= in_opt;
                  equ_q    <= in_equ;
                  beat_q   <= 3'd1;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (accept) begin
                  for (int k = 1; k < CC_NUM_OPS; k++) begin
                     if (beat_q == 3'(k)) begin
                        ops_q[k] <= in_data;
                     end
                  end
                  if (beat_q == 3'(CC_NUM_OPS - 1)) begin
                     beat_q     <= '0;
                     wait_q     <= 3'(RESP_LAT - 1);
                     in_ready_q <= 1'b0;
                     state_q    <= WAIT;
                  end else begin
                     beat_q <= beat_q + 3'd1;
                  end
               end
            end
            WAIT: begin
               if (wait_q == 3'd0) begin
                  out_value_q <= cc_out_n;
                  out_valid_q <= 1'b1;
                  state_q     <= OUT;
               end else begin
                  wait_q <= wait_q - 3'd1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign cc_opt    = opt_q;
   assign cc_equ    = equ_q;
   assign cc_n0     = ops_q[0];
   assign cc_n1     = ops_q[1];
   assign cc_n2     = ops_q[2];
   assign cc_n3     = ops_q[3];
   assign cc_n4     = ops_q[4];
   assign cc_n5     = ops_q[5];

endmodule

// File: tb/tb_cc_frame_driver.sv
// Bench for cc_frame_driver: two instances (RESP_LAT 1 and 4) each feeding a stand-in CC
// whose result mixes the bundle with a free-running cycle stamp, so capture edge and bundle stability both show.
module tb_cc_frame_driver;

   typedef logic [5:0][3:0] ops_t;

   typedef struct {
      ops_t       ops;
      logic [2:0] opt;
      logic       equ;
      int         gap;
      int         bp;
      int         dut;
      logic [9:0] exp_mix;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid  [2];
   logic       in_ready  [2];
   logic [3:0] in_data   [2];
   logic [2:0] in_opt    [2];
   logic       in_equ    [2];
   logic [3:0] cc_n      [2][6];
   logic [2:0] cc_opt    [2];
   logic       cc_equ    [2];
   logic [9:0] cc_out_n  [2];
   logic       out_valid [2];
   logic       out_ready [2];
   logic [9:0] out_value [2];

   logic [9:0] cyc = '0;
   int n_vec = 0;
   int n_bad = 0;
   int rises [2];
   int rise_at [2][2];
   logic prev_valid [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 10'd1;

   // Stand-in CC: position-sensitive mix of the bundle plus the current cycle stamp.
   function automatic logic [9:0] mix(input logic [3:0] a0, a1, a2, a3, a4, a5,
                                      input logic [2:0] opt, input logic equ);
      logic [3:0] a [6];
      logic [9:0] r;
      a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3; a[4] = a4; a[5] = a5;
      r = {equ, opt, 6'd0};
      for (int k = 0; k < 6; k++) begin
         r = {r[8:0], r[9]} ^ (10'(a[k]) * 10'(k + 3));
      end
      return r;
   endfunction

   assign cc_out_n[0] = mix(cc_n[0][0], cc_n[0][1], cc_n[0][2], cc_n[0][3], cc_n[0][4],
                            cc_n[0][5], cc_opt[0], cc_equ[0]) + cyc;
   assign cc_out_n[1] = mix(cc_n[1][0], cc_n[1][1], cc_n[1][2], cc_n[1][3], cc_n[1][4],
                            cc_n[1][5], cc_opt[1], cc_equ[1]) + cyc;

   cc_frame_driver #(.RESP_LAT(1)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .in_opt(in_opt[0]), .in_equ(in_equ[0]),
      .cc_n0(cc_n[0][0]), .cc_n1(cc_n[0][1]), .cc_n2(cc_n[0][2]),
      .cc_n3(cc_n[0][3]), .cc_n4(cc_n[0][4]), .cc_n5(cc_n[0][5]),
      .cc_opt(cc_opt[0]), .cc_equ(cc_equ[0]), .cc_out_n(cc_out_n[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_value(out_value[0])
   );

   cc_frame_driver #(.RESP_LAT(4)) u_dut_l4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .in_opt(in_opt[1]), .in_equ(in_equ[1]),
      .cc_n0(cc_n[1][0]), .cc_n1(cc_n[1][1]), .cc_n2(cc_n[1][2]),
      .cc_n3(cc_n[1][3]), .cc_n4(cc_n[1][4]), .cc_n5(cc_n[1][5]),
      .cc_opt(cc_opt[1]), .cc_equ(cc_equ[1]), .cc_out_n(cc_out_n[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_value(out_value[1])
   );

   // Records the cycle stamp of each out_valid rise per instance.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (out_valid[d] === 1'b1 && prev_valid[d] !== 1'b1) begin
            rises[d]      = rises[d] + 1;
            rise_at[d][0] = rise_at[d][1];
            rise_at[d][1] = int'(cyc);
         end
         prev_valid[d] = out_valid[d];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t make_vec(input ops_t ops, input logic [2:0] opt, input logic equ,
                                     input int gap, input int bp, input int dut);
      vec_t v;
      v.ops = ops; v.opt = opt; v.equ = equ;
      v.gap = gap; v.bp = bp; v.dut = dut;
      v.exp_mix = mix(ops[0], ops[1], ops[2], ops[3], ops[4], ops[5], opt, equ);
      return v;
   endfunction

   task automatic check_bundle(input int d, input vec_t v, input int upto);
      for (int k = 0; k <= upto; k++) begin
         check($sformatf("cc_n%0d", k), 32'(cc_n[d][k]), 32'(v.ops[k]));
      end
      check("cc_opt", 32'(cc_opt[d]), 32'(v.opt));
      check("cc_equ", 32'(cc_equ[d]), 32'(v.equ));
   endtask

   task automatic check_reset_outputs(input int d, input logic exp_ready);
      check("rst_in_ready", 32'(in_ready[d]), 32'(exp_ready));
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_out_value", 32'(out_value[d]), 32'd0);
      check("rst_cc_opt", 32'(cc_opt[d]), 32'd0);
      check("rst_cc_equ", 32'(cc_equ[d]), 32'd0);
      for (int k = 0; k < 6; k++) begin
         check($sformatf("rst_cc_n%0d", k), 32'(cc_n[d][k]), 32'd0);
      end
   endtask

   // Drives one frame from a negedge and checks every cycle through the output handshake.
   task automatic run_frame(input vec_t v);
      int         d;
      int         lat;
      logic [9:0] c;
      logic [9:0] expv;
      d   = v.dut;
      lat = (d == 0) ? 1 : 4;
      c   = '0;
      out_ready[d] = (v.bp == 0);
      for (int k = 0; k < 6; k++) begin
         for (int g = 0; g < v.gap; g++) begin
            in_valid[d] = 1'b0;
            in_data[d]  = 4'($urandom);
            in_opt[d]   = 3'($urandom);
            @(negedge clk);
            check("gap_in_ready", 32'(in_ready[d]), 32'd1);
            if (k > 0) check_bundle(d, v, k - 1);
         end
         check("beat_in_ready", 32'(in_ready[d]), 32'd1);
         in_valid[d] = 1'b1;
         in_data[d]  = v.ops[k];
         in_opt[d]   = (k == 0) ? v.opt : 3'($urandom);
         in_equ[d]   = (k == 0) ? v.equ : 1'($urandom);
         c = cyc;
         @(negedge clk);
         in_valid[d] = 1'b0;
         check_bundle(d, v, k);
      end
      expv = v.exp_mix + c + 10'(lat);
      for (int i = 0; i < lat; i++) begin
         check("wait_out_valid", 32'(out_valid[d]), 32'd0);
         check("wait_in_ready", 32'(in_ready[d]), 32'd0);
         check_bundle(d, v, 5);
         @(negedge clk);
      end
      for (int i = 0; i < v.bp; i++) begin
         check("bp_out_valid", 32'(out_valid[d]), 32'd1);
         check("bp_out_value", 32'(out_value[d]), 32'(expv));
         check("bp_in_ready", 32'(in_ready[d]), 32'd0);
         @(negedge clk);
      end
      out_ready[d] = 1'b1;
      check("out_valid", 32'(out_valid[d]), 32'd1);
      check("out_value", 32'(out_value[d]), 32'(expv));
      check("out_in_ready", 32'(in_ready[d]), 32'd0);
      @(negedge clk);
      check("post_out_valid", 32'(out_valid[d]), 32'd0);
      check("post_in_ready", 32'(in_ready[d]), 32'd1);
      check("post_out_value_hold", 32'(out_value[d]), 32'(expv));
   endtask

   vec_t tbl [7];
   vec_t rv;
   vec_t vr;
   int   r0;

   initial begin
      for (int d = 0; d < 2; d++) begin
         in_valid[d] = 1'b0; in_data[d] = '0; in_opt[d] = '0; in_equ[d] = 1'b0;
         out_ready[d] = 1'b0; rises[d] = 0; prev_valid[d] = 1'b0;
         rise_at[d][0] = 0; rise_at[d][1] = 0;
      end

      tbl[0] = make_vec(24'h654321, 3'b000, 1'b1, 0, 0, 0);
      tbl[1] = make_vec(24'h654321, 3'b000, 1'b0, 2, 0, 0);
      tbl[2] = make_vec(24'h654321, 3'b101, 1'b1, 0, 5, 0);
      tbl[3] = make_vec(24'h654321, 3'b011, 1'b1, 0, 0, 1);
      tbl[4] = make_vec(24'hffffff, 3'b111, 1'b1, 1, 2, 1);
      tbl[5] = make_vec(24'h000000, 3'b000, 1'b0, 0, 1, 0);
      tbl[6] = make_vec(24'h0f0f0f, 3'b110, 1'b0, 2, 0, 1);

      rst = 1'b1;
      #1;
      check_reset_outputs(0, 1'b0);
      check_reset_outputs(1, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rel_in_ready0", 32'(in_ready[0]), 32'd0);
      @(negedge clk);
      check("first_in_ready0", 32'(in_ready[0]), 32'd1);
      check("first_in_ready1", 32'(in_ready[1]), 32'd1);

      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i]);
      end

      // Reset after beat 3 of an in-flight frame.
      for (int k = 0; k < 4; k++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 4'(9 + k);
         in_opt[0]   = 3'b111;
         in_equ[0]   = 1'b0;
         @(negedge clk);
      end
      in_valid[0] = 1'b0;
      rst = 1'b1;
      #1;
      check_reset_outputs(0, 1'b0);
      check_reset_outputs(1, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rel_in_ready", 32'(in_ready[0]), 32'd0);
      @(negedge clk);
      check("mid_first_in_ready", 32'(in_ready[0]), 32'd1);
      check("mid_out_valid", 32'(out_valid[0]), 32'd0);
      run_frame(make_vec(24'h654321, 3'b000, 1'b1, 0, 0, 0));

      // Back-to-back frames: two rises, period 6 + RESP_LAT + 1.
      for (int d = 0; d < 2; d++) begin
         #1;
         r0 = rises[d];
         run_frame(make_vec(24'h123456, 3'b010, 1'b1, 0, 0, d));
         run_frame(make_vec(24'hcafe12, 3'b001, 1'b0, 0, 0, d));
         #1;
         check("b2b_rises", 32'(rises[d] - r0), 32'd2);
         check("b2b_period", 32'(rise_at[d][1] - rise_at[d][0]), 32'(d == 0 ? 8 : 11));
      end

      for (int i = 0; i < 20; i++) begin
         vr = make_vec(ops_t'({$urandom, $urandom}), 3'($urandom), 1'($urandom),
                       int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)));
         rv = vr;
         run_frame(rv);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/cc_frame_driver.md
# cc_frame_driver

Sequential front end for the combinational CC sort/normalise/compute datapath. It accepts one 4-bit operand per handshake beat, assembles a six-operand frame plus the `opt`/`equ` controls, and drives them as a stable registered bundle into CC. After a fixed settle delay it captures CC's 10-bit signed result and returns it over a valid/ready output handshake. It acts as the initiator, and result collector, for CC's operand bus.

## Interface
- `RESP_LAT`, default 1: cycles from bundle complete to result capture; legal range 1–7.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: driver can accept a beat.
- `in_data` input 4: operand nibble; beat k feeds `cc_n{k}`.
- `in_opt` input 3: frame options; sampled on beat 0 only.
- `in_equ` input 1: equation select; sampled on beat 0 only.
- `cc_n0..cc_n5` output 4 each: registered operands to CC.
- `cc_opt` output 3: registered to CC `opt`.
- `cc_equ` output 1: registered to CC `equ`.
- `cc_out_n` input 10: signed result from CC.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_value` output 10: captured signed result.

## Operation
- A beat is accepted when `in_valid && in_ready`. Only accepted beats advance the 3-bit beat counter (0..5).
- Beats need not be consecutive. While `in_valid` is low, the counter and registers hold.
- Beat 0 latches `in_opt` into `cc_opt` and `in_equ` into `cc_equ`. On beats 1..5, `in_opt` and `in_equ` are ignored.
- FSM states:
  - IDLE: `in_ready`=1, counter=0. An accepted beat writes `cc_n0`, moves to LOAD, counter=1.
  - LOAD: `in_ready`=1. An accepted beat k writes `cc_n{k}`. When beat 5 is accepted, go to WAIT and load the wait counter with `RESP_LAT`-1.
  - WAIT: `in_ready`=0. The wait counter decrements each cycle. When it is 0, capture `cc_out_n` into `out_value`, set `out_valid`=1, and go to OUT.
  - OUT: `in_ready`=0. `out_valid` and `out_value` hold until `out_ready`=1. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- The `cc_*` bundle holds its last frame after completion and into IDLE. It is overwritten beat by beat by the next frame; no clearing between frames.
- `out_value` is a sign-preserving 10-bit copy of `cc_out_n` with no arithmetic. It holds after handoff until the next capture.
- Reset, at any time and mid-frame included: all outputs and registers go to 0 and the FSM goes to IDLE. The partial frame is discarded. `in_ready`=1 from the first clock edge after `rst` deasserts; `out_valid`=0.

## Timing
- Reset values: `in_ready`=0 while `rst` is high and 1 after. `out_valid`=0, `out_value`=0, all `cc_n*`=0, `cc_opt`=0, `cc_equ`=0.
- Write timing: `cc_n{k}` updates at the edge accepting beat k.
- Capture timing: if beat 5 is accepted at edge E, capture happens at edge E+`RESP_LAT`. `out_valid` is high from that edge, so CC always sees a bundle stable for ≥`RESP_LAT` cycles.
- Minimum frame period: 6 + `RESP_LAT` + 1 cycles with `out_ready` tied high.
- No overlap: `in_ready` rises the cycle after the output handshake completes.
- `out_ready` high before `out_valid` is legal and completes the handshake in the first valid cycle.
- No combinational paths from input to output: every output is a flop or decodes only the FSM state.

## Structure
- Shared package `cc_pkg`:
  - FSM enum `cc_drv_state_t` {IDLE, LOAD, WAIT, OUT}.
  - Constants: `CC_NUM_OPS`=6, `CC_OP_W`=4, `CC_RES_W`=10, `CC_OPT_W`=3.
- The block is one module: FSM, beat counter, wait counter, and operand/result registers. No sub-module is required.
- The test top instantiates `cc_frame_driver` and CC back to back on the `cc_*` bus.

## Test plan
- **Equation result:** frame 1,2,3,4,5,6, `opt`=000, `equ`=1, consecutive beats, `out_ready`=1, `RESP_LAT`=1 -> `out_value`=5. `out_valid` rises exactly 1 cycle after beat 5 and lasts 1 cycle.
- **Other equation, gaps:** same frame with `equ`=0 and 2-cycle `in_valid` gaps between beats -> `out_value`=31; counter holds through the gaps; `in_opt` changes on beats 1..5 have no effect.
- **Back-pressure:** `out_ready`=0 for 5 cycles after `out_valid` -> `out_value` stable, `in_ready`=0 throughout; handshake on cycle 6, `in_ready`=1 on the following cycle.
- **Settle delay:** `RESP_LAT`=4 -> capture 4 cycles after beat 5; `cc_n*`, `cc_opt` and `cc_equ` unchanged during WAIT.
- **Reset mid-operation:** assert `rst` after beat 3 -> all outputs 0 and FSM in IDLE. A following full frame 1..6 with `equ`=1 yields `out_value`=5 with no residue from the aborted frame.
- **Back-to-back frames:** two frames with `out_ready`=1 -> exactly two `out_valid` pulses, with period 6+`RESP_LAT`+1 cycles.
